// File: rtl/dpmem_arb_pkg.sv
// Shared types and constants for the dual-port memory request arbiter.
package dpmem_arb_pkg;

    typedef enum logic {
        PORT1 = 1'b0,
        PORT2 = 1'b1
    } port_e;

    // Wide enough for the largest supported requester count (16).
    localparam int TAG_IDX_W = 4;

    typedef struct packed {
        logic                 vld;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    // Truncated to the counter width at the point of use.
    localparam logic [63:0] CONFLICT_CNT_MAX = '1;

endpackage

// File: rtl/dpmem_rr_picker.sv
// Circular find-first-set over a request mask, starting at a given index.
module dpmem_rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

    // Scan downwards so the candidate closest to start is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(start) + k) % N);
            if (mask[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/dpmem_req_arbiter.sv
// Round-robin arbiter sharing both ports of the dual-port memory between N_REQ
// requesters, with same-address deferral and tagged read-data return.
module dpmem_req_arbiter
    import dpmem_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 256,
    parameter  int CNT_W   = 16,
    parameter  int SIM_DLY = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ-1:0]           req_wr,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wr_data,
    output logic [N_REQ-1:0]           req_gnt,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic [N_REQ*DATA_W-1:0]    rsp_data,
    output logic                       p1_rd_req,
    output logic                       p1_wr_req,
    output logic [ADDR_W-1:0]          p1_addr,
    output logic [DATA_W-1:0]          p1_wr_data,
    input  logic                       p1_rd_data_valid,
    input  logic [DATA_W-1:0]          p1_rd_data,
    output logic                       p2_rd_req,
    output logic                       p2_wr_req,
    output logic [ADDR_W-1:0]          p2_addr,
    output logic [DATA_W-1:0]          p2_wr_data,
    input  logic                       p2_rd_data_valid,
    input  logic [DATA_W-1:0]          p2_rd_data,
    output logic [CNT_W-1:0]           conflict_cnt
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFLICT_CNT_MAX);

    // Flop updates are zero-delay; SIM_DLY is accepted only for drop-in compatibility.
    if (N_REQ < 2 || N_REQ > 16 || SIM_DLY < 0) begin : g_bad_param
        $error("dpmem_req_arbiter: unsupported parameter values");
    end

    logic [N_REQ-1:0][ADDR_W-1:0] addr;
    logic [N_REQ-1:0][DATA_W-1:0] wdata;
    logic [N_REQ-1:0][DATA_W-1:0] rsp_data_q;
    logic [IW-1:0]                ptr, a_idx, b_idx, b_start;
    logic                         a_found, b_found;
    logic [N_REQ-1:0]             b_mask, defer, hit1, hit2;
    tag_t [1:0]                   tag;

    assign addr     = req_addr;
    assign wdata    = req_wr_data;
    assign rsp_data = rsp_data_q;

    dpmem_rr_picker #(.N(N_REQ)) u_pick_a (
        .mask  (req_vld),
        .start (ptr),
        .found (a_found),
        .idx   (a_idx)
    );

    assign b_start = (a_idx == IW'(N_REQ - 1)) ? '0 : a_idx + IW'(1);

    // Anything sharing A's address is held back so the two ports never collide.
    always_comb begin
        b_mask = '0;
        defer  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_vld[i] && IW'(i) != a_idx) begin
                if (addr[i] == addr[a_idx]) defer[i]  = 1'b1;
                else                        b_mask[i] = 1'b1;
            end
        end
    end

    dpmem_rr_picker #(.N(N_REQ)) u_pick_b (
        .mask  (b_mask),
        .start (b_start),
        .found (b_found),
        .idx   (b_idx)
    );

    always_comb begin
        req_gnt = '0;
        if (a_found) req_gnt[a_idx] = 1'b1;
        if (b_found) req_gnt[b_idx] = 1'b1;
    end

    assign p1_rd_req  = a_found & ~req_wr[a_idx];
    assign p1_wr_req  = a_found &  req_wr[a_idx];
    assign p1_addr    = a_found ? addr[a_idx]  : '0;
    assign p1_wr_data = a_found ? wdata[a_idx] : '0;

    assign p2_rd_req  = b_found & ~req_wr[b_idx];
    assign p2_wr_req  = b_found &  req_wr[b_idx];
    assign p2_addr    = b_found ? addr[b_idx]  : '0;
    assign p2_wr_data = b_found ? wdata[b_idx] : '0;

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hit1[i] = p1_rd_data_valid & tag[PORT1].vld & (tag[PORT1].idx == TAG_IDX_W'(i));
            hit2[i] = p2_rd_data_valid & tag[PORT2].vld & (tag[PORT2].idx == TAG_IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            tag          <= '0;
            rsp_vld      <= '0;
            rsp_data_q   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (a_found) ptr <= b_start;
            tag[PORT1] <= '{vld: p1_rd_req, idx: TAG_IDX_W'(a_idx)};
            tag[PORT2] <= '{vld: p2_rd_req, idx: TAG_IDX_W'(b_idx)};
            if (|defer && conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + CNT_W'(1);
            for (int i = 0; i < N_REQ; i++) begin
                rsp_vld[i] <= hit1[i] | hit2[i];
                if (hit1[i])      rsp_data_q[i] <= p1_rd_data;
                else if (hit2[i]) rsp_data_q[i] <= p2_rd_data;
            end
        end
    end

endmodule
